// File: rtl/nes_debugger_mem_arbiter.sv
// Single-port memory arbiter: debugger has top priority, NES writes are posted into a
// small write buffer, and reads from either side forward the youngest buffered data.
module nes_debugger_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_nes_en,
  input  logic                          i_nes_rw,
  input  logic [ADDR_WIDTH-1:0]         i_nes_address,
  input  logic [DATA_WIDTH-1:0]         i_nes_data,
  output logic                          o_nes_ready,
  output logic [DATA_WIDTH-1:0]         o_nes_data,
  output logic                          o_nes_valid,
  input  logic                          i_debugger_en,
  input  logic                          i_debugger_rw,
  input  logic [ADDR_WIDTH-1:0]         i_debugger_address,
  input  logic [DATA_WIDTH-1:0]         i_debugger_data,
  output logic [DATA_WIDTH-1:0]         o_debugger_data,
  output logic                          o_debugger_valid,
  output logic                          o_mem_en,
  output logic                          o_mem_wea,
  output logic [ADDR_WIDTH-1:0]         o_mem_address,
  output logic [DATA_WIDTH-1:0]         o_mem_data,
  input  logic [DATA_WIDTH-1:0]         i_mem_data,
  output logic [$clog2(WBUF_DEPTH):0]   o_wbuf_count
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] r_data [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] r_vld;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic                  r_nes_valid;
  logic                  r_nes_from_mem;
  logic [DATA_WIDTH-1:0] r_nes_data;
  logic                  r_dbg_valid;
  logic                  r_dbg_from_mem;
  logic [DATA_WIDTH-1:0] r_dbg_data;

  logic [PW-1:0]         w_slot [WBUF_DEPTH];
  logic                  w_nes_hit;
  logic [DATA_WIDTH-1:0] w_nes_fwd;
  logic                  w_dbg_hit;
  logic [DATA_WIDTH-1:0] w_dbg_fwd;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_nes_rd_miss;
  logic                  w_pop;
  logic                  w_nes_mem_rd;
  logic                  w_nes_wr_acc;
  logic                  w_nes_rd_acc;
  logic                  w_dbg_rd;

  // w_slot[gi] is the gi-th oldest buffer position
  for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_slot
    assign w_slot[gi] = r_head + PW'(gi);
  end

  // Scan oldest to youngest so the youngest valid match wins
  always_comb begin
    w_nes_hit = 1'b0;
    w_nes_fwd = '0;
    w_dbg_hit = 1'b0;
    w_dbg_fwd = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if (r_vld[w_slot[k]] && r_addr[w_slot[k]] == i_nes_address) begin
        w_nes_hit = 1'b1;
        w_nes_fwd = r_data[w_slot[k]];
      end
      if (r_vld[w_slot[k]] && r_addr[w_slot[k]] == i_debugger_address) begin
        w_dbg_hit = 1'b1;
        w_dbg_fwd = r_data[w_slot[k]];
      end
    end
  end

  assign w_full        = (r_count == CW'(WBUF_DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_nes_rd_miss = i_nes_en && i_nes_rw && !w_nes_hit;
  assign w_dbg_rd      = i_debugger_en && i_debugger_rw;

  always_comb begin
    o_mem_en      = 1'b0;
    o_mem_wea     = 1'b0;
    o_mem_address = '0;
    o_mem_data    = '0;
    w_pop         = 1'b0;
    w_nes_mem_rd  = 1'b0;
    if (i_debugger_en) begin
      o_mem_en      = 1'b1;
      o_mem_wea     = !i_debugger_rw;
      o_mem_address = i_debugger_address;
      o_mem_data    = i_debugger_rw ? '0 : i_debugger_data;
    end else if (w_full || (!w_empty && !w_nes_rd_miss)) begin
      // Killed entries still pop, just without a write strobe
      o_mem_en      = 1'b1;
      o_mem_wea     = r_vld[r_head];
      o_mem_address = r_addr[r_head];
      o_mem_data    = r_data[r_head];
      w_pop         = 1'b1;
    end else if (w_nes_rd_miss) begin
      o_mem_en      = 1'b1;
      o_mem_address = i_nes_address;
      w_nes_mem_rd  = 1'b1;
    end
  end

  assign w_nes_wr_acc = i_nes_en && !i_nes_rw && (!w_full || w_pop);
  assign w_nes_rd_acc = i_nes_en && i_nes_rw && !i_debugger_en && !w_full &&
                        (w_nes_hit || w_nes_mem_rd);
  assign o_nes_ready  = w_nes_wr_acc || w_nes_rd_acc;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Kill first, then pop, then push: a same-cycle NES write survives the kill
      for (int k = 0; k < WBUF_DEPTH; k++) begin
        if (i_debugger_en && !i_debugger_rw && r_addr[k] == i_debugger_address)
          r_vld[k] <= 1'b0;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_nes_wr_acc) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_nes_wr_acc) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_nes_wr_acc) begin
      r_addr[r_tail] <= i_nes_address;
      r_data[r_tail] <= i_nes_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_nes_valid    <= 1'b0;
      r_nes_from_mem <= 1'b0;
      r_nes_data     <= '0;
      r_dbg_valid    <= 1'b0;
      r_dbg_from_mem <= 1'b0;
      r_dbg_data     <= '0;
    end else begin
      r_nes_valid    <= w_nes_rd_acc;
      r_nes_from_mem <= w_nes_rd_acc && !w_nes_hit;
      if (w_nes_rd_acc && w_nes_hit)
        r_nes_data <= w_nes_fwd;
      else if (r_nes_from_mem)
        r_nes_data <= i_mem_data;
      r_dbg_valid    <= w_dbg_rd;
      r_dbg_from_mem <= w_dbg_rd && !w_dbg_hit;
      if (w_dbg_rd && w_dbg_hit)
        r_dbg_data <= w_dbg_fwd;
      else if (r_dbg_from_mem)
        r_dbg_data <= i_mem_data;
    end
  end

  // Memory-sourced responses appear combinationally in the cycle the data returns
  assign o_nes_data       = r_nes_from_mem ? i_mem_data : r_nes_data;
  assign o_nes_valid      = r_nes_valid;
  assign o_debugger_data  = r_dbg_from_mem ? i_mem_data : r_dbg_data;
  assign o_debugger_valid = r_dbg_valid;
  assign o_wbuf_count     = r_count;

endmodule

// File: tb/tb_nes_debugger_mem_arbiter.sv
// Bench for nes_debugger_mem_arbiter: directed scenarios plus random traffic checked
// against a queue-of-posted-writes model and a logical memory image.
module tb_nes_debugger_mem_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nes_en = 1'b0, nes_rw = 1'b0;
  logic [15:0] nes_addr = '0;
  logic [7:0]  nes_data = '0;
  logic        dbg_en = 1'b0, dbg_rw = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [7:0]  dbg_data = '0;
  logic        o_nes_ready, o_nes_valid, o_dbg_valid;
  logic [7:0]  o_nes_data, o_dbg_data;
  logic        o_mem_en, o_mem_wea;
  logic [15:0] o_mem_address;
  logic [7:0]  o_mem_data;
  logic [7:0]  mem_rdata = '0;
  logic [2:0]  o_wbuf_count;

  nes_debugger_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WBUF_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_nes_en(nes_en), .i_nes_rw(nes_rw), .i_nes_address(nes_addr), .i_nes_data(nes_data),
    .o_nes_ready(o_nes_ready), .o_nes_data(o_nes_data), .o_nes_valid(o_nes_valid),
    .i_debugger_en(dbg_en), .i_debugger_rw(dbg_rw), .i_debugger_address(dbg_addr),
    .i_debugger_data(dbg_data), .o_debugger_data(o_dbg_data), .o_debugger_valid(o_dbg_valid),
    .o_mem_en(o_mem_en), .o_mem_wea(o_mem_wea), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .i_mem_data(mem_rdata), .o_wbuf_count(o_wbuf_count)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with one-cycle read latency
  logic [7:0] mem [65536];
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_wea) mem[o_mem_address] <= o_mem_data;
      else           mem_rdata <= mem[o_mem_address];
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          v;
  } ent_t;

  ent_t       q[$];
  logic [7:0] ref_mem [65536];
  bit         nes_pend, dbg_pend, nes_acc;
  logic [7:0] nes_exp, dbg_exp;
  logic       s_ready;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit q_hit(input logic [15:0] a);
    bit h = 1'b0;
    foreach (q[k]) if (q[k].v && q[k].a == a) h = 1'b1;
    return h;
  endfunction

  // One clock of checking and model update; returns 1 ns after the next posedge
  task automatic step();
    bit full, miss, exp_rdy;
    @(negedge clk);
    s_ready = o_nes_ready;
    chk("wbuf_count", 32'(o_wbuf_count), q.size());
    chk("nes_valid", 32'(o_nes_valid), 32'(nes_pend));
    if (nes_pend) chk("nes_data", 32'(o_nes_data), 32'(nes_exp));
    chk("dbg_valid", 32'(o_dbg_valid), 32'(dbg_pend));
    if (dbg_pend) chk("dbg_data", 32'(o_dbg_data), 32'(dbg_exp));
    nes_pend = 1'b0;
    dbg_pend = 1'b0;
    full = (q.size() == DEPTH);
    if (dbg_en) begin
      chk("dbg_mem_en", 32'(o_mem_en), 1);
      chk("dbg_mem_addr", 32'(o_mem_address), 32'(dbg_addr));
      chk("dbg_mem_wea", 32'(o_mem_wea), 32'(!dbg_rw));
      if (!dbg_rw) begin
        chk("dbg_mem_data", 32'(o_mem_data), 32'(dbg_data));
        ref_mem[dbg_addr] = dbg_data;
        foreach (q[k]) if (q[k].a == dbg_addr) q[k].v = 1'b0;
      end else begin
        dbg_pend = 1'b1;
        dbg_exp  = ref_mem[dbg_addr];
      end
    end
    miss = nes_en && nes_rw && !q_hit(nes_addr);
    exp_rdy = nes_en && (nes_rw ? (!dbg_en && !full) : (!full || !dbg_en));
    chk("nes_ready", 32'(o_nes_ready), 32'(exp_rdy));
    if (!dbg_en) begin
      if (q.size() > 0 && (full || !miss)) begin
        chk("drain_en", 32'(o_mem_en), 1);
        chk("drain_addr", 32'(o_mem_address), 32'(q[0].a));
        chk("drain_wea", 32'(o_mem_wea), 32'(q[0].v));
        if (q[0].v) chk("drain_data", 32'(o_mem_data), 32'(q[0].d));
        void'(q.pop_front());
      end else if (miss) begin
        chk("nesrd_en", 32'(o_mem_en), 1);
        chk("nesrd_wea", 32'(o_mem_wea), 0);
        chk("nesrd_addr", 32'(o_mem_address), 32'(nes_addr));
      end else begin
        chk("idle_mem_en", 32'(o_mem_en), 0);
      end
    end
    nes_acc = exp_rdy;
    if (exp_rdy) begin
      if (!nes_rw) begin
        q.push_back('{a: nes_addr, d: nes_data, v: 1'b1});
        ref_mem[nes_addr] = nes_data;
      end else begin
        nes_pend = 1'b1;
        nes_exp  = ref_mem[nes_addr];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    nes_en = 1'b0;
    dbg_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain_all();
    nes_en = 1'b0;
    dbg_en = 1'b0;
    for (int i = 0; i < 40 && (q.size() != 0 || nes_pend || dbg_pend); i++) step();
    chk("drain_bound", q.size(), 0);
  endtask

  task automatic nes_op(input logic rw, input logic [15:0] a, input logic [7:0] d);
    nes_en = 1'b1; nes_rw = rw; nes_addr = a; nes_data = d;
    for (int i = 0; i < 20; i++) begin
      step();
      if (nes_acc) break;
    end
    chk("nes_op_accepted", 32'(nes_acc), 1);
    nes_en = 1'b0;
  endtask

  task automatic dbg_op(input logic rw, input logic [15:0] a, input logic [7:0] d);
    dbg_en = 1'b1; dbg_rw = rw; dbg_addr = a; dbg_data = d;
    step();
    dbg_en = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    nes_pend = 1'b0;
    dbg_pend = 1'b0;
    nes_acc  = 1'b0;
    ref_mem  = mem;
  endtask

  initial begin
    logic [7:0] pre0600;
    int diffs;
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(o_wbuf_count), 0);
    chk("rst_mem_en", 32'(o_mem_en), 0);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_nes_data", 32'(o_nes_data), 0);
    chk("rst_dbg_data", 32'(o_dbg_data), 0);
    chk("rst_nes_valid", 32'(o_nes_valid), 0);
    chk("rst_dbg_valid", 32'(o_dbg_valid), 0);
    idle(2);

    // Single posted write, drained on the following cycle
    nes_op(1'b0, 16'h0200, 8'h12);
    chk("t1_ready_same_cycle", 32'(s_ready), 1);
    idle(1);
    drain_all();

    // Debugger hogs the port while NES fills the buffer
    begin
      int wi = 0;
      for (int c = 0; c < 12; c++) begin
        dbg_en = (c < 6); dbg_rw = 1'b1; dbg_addr = 16'h0100;
        nes_en = (wi < 5); nes_rw = 1'b0;
        nes_addr = 16'h0300 + 16'(wi); nes_data = 8'(wi + 1);
        step();
        if (c == 4) chk("t2_full_stall", 32'(s_ready), 0);
        if (nes_acc && wi < 5) wi++;
      end
      chk("t2_all_written", wi, 5);
    end
    drain_all();

    // Youngest buffered write forwarded to an NES read
    nes_op(1'b0, 16'h0010, 8'hAA);
    nes_op(1'b0, 16'h0010, 8'hBB);
    nes_op(1'b1, 16'h0010, 8'h00);
    idle(1);
    chk("t3_fwd_data", 32'(o_nes_data), 32'h0BB);
    drain_all();

    // Debugger write kills the older posted write to the same address
    dbg_en = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0100;
    nes_op(1'b0, 16'h0040, 8'h55);
    dbg_op(1'b0, 16'h0040, 8'h66);
    drain_all();
    dbg_op(1'b1, 16'h0040, 8'h00);
    idle(1);
    chk("t4_dbg_read", 32'(o_dbg_data), 32'h066);
    chk("t4_mem", 32'(mem[16'h0040]), 32'h066);

    // Simultaneous debugger and NES reads
    dbg_op(1'b0, 16'h0500, 8'h77);
    dbg_op(1'b0, 16'h0501, 8'h88);
    dbg_en = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0500;
    nes_en = 1'b1; nes_rw = 1'b1; nes_addr = 16'h0501;
    step();
    chk("t5_nes_stalled", 32'(s_ready), 0);
    dbg_en = 1'b0;
    chk("t5_dbg_data", 32'(o_dbg_data), 32'h077);
    step();
    chk("t5_nes_served", 32'(s_ready), 1);
    idle(1);
    chk("t5_nes_data", 32'(o_nes_data), 32'h088);
    idle(2);

    // Reset with three posted writes pending
    pre0600 = mem[16'h0600];
    dbg_en = 1'b1; dbg_rw = 1'b1; dbg_addr = 16'h0100;
    nes_op(1'b0, 16'h0600, 8'hC1);
    nes_op(1'b0, 16'h0601, 8'hC2);
    nes_op(1'b0, 16'h0602, 8'hC3);
    chk("t6_count_before", 32'(o_wbuf_count), 3);
    nes_en = 1'b0; dbg_en = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("t6_rst_count", 32'(o_wbuf_count), 0);
    chk("t6_rst_nes_valid", 32'(o_nes_valid), 0);
    chk("t6_rst_dbg_valid", 32'(o_dbg_valid), 0);
    chk("t6_rst_mem_en", 32'(o_mem_en), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(4);
    chk("t6_no_write", 32'(mem[16'h0600]), 32'(pre0600));

    // Random traffic over a small address window
    for (int c = 0; c < 600; c++) begin
      dbg_en   = ($urandom_range(0, 3) == 0);
      dbg_rw   = $urandom_range(0, 1) == 1;
      dbg_addr = 16'h0200 + 16'($urandom_range(0, 7));
      dbg_data = 8'($urandom);
      if (!nes_en || nes_acc) begin
        nes_en   = ($urandom_range(0, 3) != 0);
        nes_rw   = ($urandom_range(0, 2) == 0);
        nes_addr = 16'h0200 + 16'($urandom_range(0, 7));
        nes_data = 8'($urandom);
      end
      step();
    end
    drain_all();
    idle(1);
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("final_mem_image", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
